// File: rtl/stack_frame_reverser.sv
// Stream-to-stack initiator: pushes each frame segment into an external LIFO, then pops it back
// out so every segment leaves in reverse beat order.
module stack_frame_reverser #(
  parameter int unsigned DPT = 16,
  parameter int unsigned DW = 8,
  localparam int unsigned CNTW = $clog2(DPT + 1)
) (
  input  logic          clk,
  input  logic          areset,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  input  logic          s_last,
  output logic          s_ready,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  input  logic          m_ready,
  output logic          o_push_en,
  output logic [DW-1:0] o_push_data,
  input  logic          i_full,
  output logic          o_pop_en,
  input  logic [DW-1:0] i_pop_data,
  input  logic          i_empty,
  output logic          o_trunc,
  output logic          o_err
);

  typedef enum logic {StFill, StDrain} state_e;

  state_e          r_state, w_state_d;
  logic [CNTW-1:0] r_cnt, w_cnt_d;
  logic            r_seg_last, w_seg_last_d;
  logic            r_idle, w_idle_d;
  logic            r_trunc, w_trunc_d;
  logic            r_err;
  logic            w_push, w_pop, w_cnt_zero, w_cnt_full, w_mismatch;

  always_comb begin
    w_cnt_zero  = (r_cnt == '0);
    w_cnt_full  = (r_cnt == CNTW'(DPT));
    w_mismatch  = (w_cnt_zero != i_empty) | (w_cnt_full != i_full);
    // r_idle holds off new input for the one cycle right after the final pop
    s_ready     = (r_state == StFill) & ~r_idle & ~i_full;
    w_push      = s_valid & s_ready;
    m_valid     = (r_state == StDrain) & ~i_empty;
    w_pop       = m_valid & m_ready;
    m_data      = i_pop_data;
    m_last      = m_valid & r_seg_last & (r_cnt == CNTW'(1));
    o_push_en   = w_push;
    o_push_data = s_data;
    o_pop_en    = w_pop;
    o_trunc     = r_trunc;
    o_err       = r_err;
  end

  always_comb begin
    w_state_d    = r_state;
    w_cnt_d      = r_cnt;
    w_seg_last_d = r_seg_last;
    w_idle_d     = 1'b0;
    w_trunc_d    = 1'b0;
    case (r_state)
      StFill: begin
        if (w_push) begin
          if (!w_cnt_full) w_cnt_d = r_cnt + CNTW'(1);
          if (s_last) begin
            w_state_d    = StDrain;
            w_seg_last_d = 1'b1;
          end else if (r_cnt == CNTW'(DPT - 1)) begin
            w_state_d    = StDrain;
            w_seg_last_d = 1'b0;
            w_trunc_d    = 1'b1;
          end
        end
      end
      StDrain: begin
        if (w_pop) begin
          if (!w_cnt_zero) w_cnt_d = r_cnt - CNTW'(1);
          if (r_cnt == CNTW'(1)) begin
            w_state_d = StFill;
            w_idle_d  = 1'b1;
          end
        end
      end
      default: w_state_d = StFill;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_state    <= StFill;
      r_cnt      <= '0;
      r_seg_last <= 1'b0;
      r_idle     <= 1'b0;
      r_trunc    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      r_seg_last <= w_seg_last_d;
      r_idle     <= w_idle_d;
      r_trunc    <= w_trunc_d;
      r_err      <= r_err | w_mismatch;
    end
  end

endmodule
